// File: rtl/fifo_noc2nic_pkg.sv
// Shared definitions for the NIC receive buffer: flit-type encodings, field
// widths, the arbiter state type and small decode helpers.
package fifo_noc2nic_pkg;

  localparam int FLIT_WIDTH_DEF = 32;
  localparam int N_OF_VC        = 2;
  localparam int N_OF_VN        = 2;
  localparam int MAX_CREDIT     = 4;
  localparam int FLIT_TYPE_BITS = 2;

  typedef enum logic [1:0] {
    FT_BODY      = 2'b00,
    FT_HEAD      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  function automatic logic is_head(input flit_type_t t);
    return (t == FT_HEAD) || (t == FT_HEAD_TAIL);
  endfunction

  function automatic logic is_tail(input flit_type_t t);
    return (t == FT_TAIL) || (t == FT_HEAD_TAIL);
  endfunction

endpackage

// File: rtl/fifo_noc2nic_if.sv
// Router-link and consumer handshake bundle of the NIC receive buffer.
interface fifo_noc2nic_if
  import fifo_noc2nic_pkg::*;
#(
  parameter int FLIT_WIDTH  = FLIT_WIDTH_DEF,
  parameter int N_TOT_OF_VC = N_OF_VC * N_OF_VN,
  parameter int N_BITS_VC   = clog2(N_TOT_OF_VC)
);
  logic [FLIT_WIDTH-1:0]  in_link_i;
  logic                   is_valid_i;
  logic [N_TOT_OF_VC-1:0] credit_signal_o;
  logic [N_TOT_OF_VC-1:0] free_signal_o;
  logic [FLIT_WIDTH-1:0]  out_flit_o;
  logic [N_BITS_VC-1:0]   out_vc_id_o;
  logic                   out_valid_o;
  logic                   ready_i;
  logic                   overflow_o;

  modport slave (
    input  in_link_i, is_valid_i, ready_i,
    output credit_signal_o, free_signal_o, out_flit_o, out_vc_id_o,
           out_valid_o, overflow_o
  );

  modport master (
    output in_link_i, is_valid_i, ready_i,
    input  credit_signal_o, free_signal_o, out_flit_o, out_vc_id_o,
           out_valid_o, overflow_o
  );
endinterface

// File: rtl/fifo_noc2nic_vc_fifo.sv
// Single-VC synchronous FIFO; push is ignored when full, pop when empty.
module vc_fifo
  import fifo_noc2nic_pkg::*;
#(
  parameter int WIDTH = FLIT_WIDTH_DEF,
  parameter int DEPTH = MAX_CREDIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] front,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign front     = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= data_in;
  end
endmodule

// File: rtl/fifo_noc2nic.sv
// NIC receive buffer: per-VC FIFOs, a packet-locking round-robin read
// arbiter, and registered credit/free/overflow feedback to the router.
module fifo_noc2nic
  import fifo_noc2nic_pkg::*;
#(
  parameter int FLIT_WIDTH  = FLIT_WIDTH_DEF,
  parameter int N_TOT_OF_VC = N_OF_VC * N_OF_VN,
  parameter int N_BITS_VC   = clog2(N_TOT_OF_VC),
  parameter int VC_DEPTH    = MAX_CREDIT
) (
  input logic          clk,
  input logic          rst,
  fifo_noc2nic_if.slave link
);
  localparam int FW = FLIT_WIDTH;
  localparam int N  = N_TOT_OF_VC;
  localparam int NB = N_BITS_VC;

  logic [FW-1:0] front_s [N];
  logic [N-1:0]  full_s, empty_s, push_s, pop_s, head_front_s;
  logic [NB-1:0] in_vc_s;

  arb_state_t    state_r, state_n;
  logic [NB-1:0] lock_vc_r, lock_vc_n;
  logic [NB-1:0] rr_ptr_r, rr_ptr_n;
  logic          hold_r, hold_n;
  logic [NB-1:0] hold_vc_r, hold_vc_n;
  logic [N-1:0]  credit_r, free_r;
  logic          overflow_r;

  logic          scan_found_s, sel_valid_s, out_valid_s, accept_s;
  logic [NB-1:0] scan_vc_s, sel_vc_s, next_vc_s;
  logic [FW-1:0] sel_flit_s;
  flit_type_t    sel_type_s;

  assign in_vc_s = link.in_link_i[FW-3 -: NB];

  // Route each incoming flit to its VC; a full VC drops it.
  always_comb begin
    push_s = '0;
    for (int i = 0; i < N; i++) begin
      push_s[i] = link.is_valid_i & (in_vc_s == NB'(i)) & ~full_s[i];
    end
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_vc
      vc_fifo #(.WIDTH(FW), .DEPTH(VC_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s[g]),
        .pop     (pop_s[g]),
        .data_in (link.in_link_i),
        .front   (front_s[g]),
        .full    (full_s[g]),
        .empty   (empty_s[g])
      );
      assign head_front_s[g] = ~empty_s[g] &
          is_head(flit_type_t'(front_s[g][FW-1 -: FLIT_TYPE_BITS]));
    end
  endgenerate

  // Round-robin scan from rr_ptr; walking downward lets the closest VC win.
  always_comb begin
    scan_found_s = 1'b0;
    scan_vc_s    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx          = (int'(rr_ptr_r) + k) % N;
      scan_vc_s    = head_front_s[idx] ? NB'(idx) : scan_vc_s;
      scan_found_s = scan_found_s | head_front_s[idx];
    end
  end

  // Choose the offered VC; a stalled IDLE grant is held so out_* stay stable.
  always_comb begin
    sel_vc_s    = '0;
    sel_valid_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (hold_r) begin
          sel_vc_s    = hold_vc_r;
          sel_valid_s = 1'b1;
        end else begin
          sel_vc_s    = scan_vc_s;
          sel_valid_s = scan_found_s;
        end
      end
      ARB_LOCKED: begin
        sel_vc_s    = lock_vc_r;
        sel_valid_s = ~empty_s[lock_vc_r];
      end
      default: begin
        sel_vc_s    = '0;
        sel_valid_s = 1'b0;
      end
    endcase
  end

  assign sel_flit_s  = front_s[sel_vc_s];
  assign sel_type_s  = flit_type_t'(sel_flit_s[FW-1 -: FLIT_TYPE_BITS]);
  assign out_valid_s = sel_valid_s & ~rst;
  assign accept_s    = out_valid_s & link.ready_i;
  assign pop_s       = accept_s ? (N'(1) << sel_vc_s) : '0;
  assign next_vc_s   = (sel_vc_s == NB'(N - 1)) ? NB'(0) : sel_vc_s + NB'(1);

  // Lock FSM next state, round-robin pointer and stall hold.
  always_comb begin
    state_n   = state_r;
    lock_vc_n = lock_vc_r;
    rr_ptr_n  = rr_ptr_r;
    hold_n    = 1'b0;
    hold_vc_n = hold_vc_r;
    case (state_r)
      ARB_IDLE: begin
        if (accept_s) begin
          if (sel_type_s == FT_HEAD) begin
            state_n   = ARB_LOCKED;
            lock_vc_n = sel_vc_s;
          end else begin
            rr_ptr_n = next_vc_s;
          end
        end else begin
          hold_n    = out_valid_s;
          hold_vc_n = sel_vc_s;
        end
      end
      ARB_LOCKED: begin
        if (accept_s && is_tail(sel_type_s)) begin
          state_n  = ARB_IDLE;
          rr_ptr_n = next_vc_s;
        end else begin
          state_n = ARB_LOCKED;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // Arbiter state plus registered credit, free and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ARB_IDLE;
      lock_vc_r  <= '0;
      rr_ptr_r   <= '0;
      hold_r     <= 1'b0;
      hold_vc_r  <= '0;
      credit_r   <= '0;
      free_r     <= '0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      lock_vc_r  <= lock_vc_n;
      rr_ptr_r   <= rr_ptr_n;
      hold_r     <= hold_n;
      hold_vc_r  <= hold_vc_n;
      credit_r   <= pop_s;
      free_r     <= is_tail(sel_type_s) ? pop_s : '0;
      overflow_r <= overflow_r | (link.is_valid_i & full_s[in_vc_s]);
    end
  end

  assign link.out_valid_o     = out_valid_s;
  assign link.out_flit_o      = out_valid_s ? sel_flit_s : '0;
  assign link.out_vc_id_o     = out_valid_s ? sel_vc_s : '0;
  assign link.credit_signal_o = credit_r;
  assign link.free_signal_o   = free_r;
  assign link.overflow_o      = overflow_r;
endmodule

// File: tb/tb_fifo_noc2nic.sv
// Directed bench for fifo_noc2nic: per-cycle vector table plus hand sequences.
module tb_fifo_noc2nic;
  logic clk;
  logic rst;
  int   total;
  int   passed;

  fifo_noc2nic_if bus ();

  fifo_noc2nic dut (
    .clk  (clk),
    .rst  (rst),
    .link (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] flit;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_flit;
    logic [1:0]  e_vc;
    logic [3:0]  e_cred;
    logic [3:0]  e_free;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [31:0] f,
                     input logic rd, input logic ev, input logic [31:0] ef,
                     input logic [1:0] evc, input logic [3:0] ec,
                     input logic [3:0] efr, input logic eo);
    vec_t t;
    t.rst = r; t.vld = v; t.flit = f; t.rdy = rd;
    t.e_valid = ev; t.e_flit = ef; t.e_vc = evc;
    t.e_cred = ec; t.e_free = efr; t.e_ovf = eo;
    vecs.push_back(t);
  endtask

  // Drive one cycle's inputs at the falling edge, then settle for sampling.
  task automatic step(input logic r, input logic v, input logic [31:0] f,
                      input logic rd);
    @(negedge clk);
    rst            = r;
    bus.is_valid_i = v;
    bus.in_link_i  = f;
    bus.ready_i    = rd;
    #1;
  endtask

  task automatic check(input string name, input logic ev,
                       input logic [31:0] ef, input logic [1:0] evc,
                       input logic [3:0] ec, input logic [3:0] efr,
                       input logic eo);
    total++;
    if (bus.out_valid_o === ev && bus.out_flit_o === ef &&
        bus.out_vc_id_o === evc && bus.credit_signal_o === ec &&
        bus.free_signal_o === efr && bus.overflow_o === eo) begin
      passed++;
    end else begin
      $display("FAIL %s: got valid=%b flit=%h vc=%0d cred=%b free=%b ovf=%b, want valid=%b flit=%h vc=%0d cred=%b free=%b ovf=%b",
               name, bus.out_valid_o, bus.out_flit_o, bus.out_vc_id_o,
               bus.credit_signal_o, bus.free_signal_o, bus.overflow_o,
               ev, ef, evc, ec, efr, eo);
    end
  endtask

  initial begin
    bit got;
    total = 0;
    passed = 0;

    // single packet: head/body/tail on VC 2
    add(0,1,32'h60000001,1, 0,32'h0,2'd0,4'b0000,4'b0000,0);
    add(0,1,32'h20000002,1, 1,32'h60000001,2'd2,4'b0000,4'b0000,0);
    add(0,1,32'hA0000003,1, 1,32'h20000002,2'd2,4'b0100,4'b0000,0);
    add(0,0,32'h0,1,        1,32'hA0000003,2'd2,4'b0100,4'b0000,0);
    add(0,0,32'h0,1,        0,32'h0,2'd0,4'b0100,4'b0100,0);
    add(0,0,32'h0,1,        0,32'h0,2'd0,4'b0000,4'b0000,0);
    // no interleaving: VC 1 head-tail waits for VC 2 packet
    add(0,1,32'h60000001,1, 0,32'h0,2'd0,4'b0000,4'b0000,0);
    add(0,1,32'hD0000005,1, 1,32'h60000001,2'd2,4'b0000,4'b0000,0);
    add(0,1,32'h20000002,1, 0,32'h0,2'd0,4'b0100,4'b0000,0);
    add(0,1,32'hA0000003,1, 1,32'h20000002,2'd2,4'b0000,4'b0000,0);
    add(0,0,32'h0,1,        1,32'hA0000003,2'd2,4'b0100,4'b0000,0);
    add(0,0,32'h0,1,        1,32'hD0000005,2'd1,4'b0100,4'b0100,0);
    add(0,0,32'h0,1,        0,32'h0,2'd0,4'b0010,4'b0010,0);
    add(0,0,32'h0,1,        0,32'h0,2'd0,4'b0000,4'b0000,0);
    // round-robin after reset: grant order 0, 1, 3
    add(1,0,32'h0,0,        0,32'h0,2'd0,4'b0000,4'b0000,0);
    add(0,1,32'hC0000010,0, 0,32'h0,2'd0,4'b0000,4'b0000,0);
    add(0,1,32'hD0000011,0, 1,32'hC0000010,2'd0,4'b0000,4'b0000,0);
    add(0,1,32'hF0000013,0, 1,32'hC0000010,2'd0,4'b0000,4'b0000,0);
    add(0,0,32'h0,1,        1,32'hC0000010,2'd0,4'b0000,4'b0000,0);
    add(0,0,32'h0,1,        1,32'hD0000011,2'd1,4'b0001,4'b0001,0);
    add(0,0,32'h0,1,        1,32'hF0000013,2'd3,4'b0010,4'b0010,0);
    add(0,0,32'h0,1,        0,32'h0,2'd0,4'b1000,4'b1000,0);
    add(0,0,32'h0,1,        0,32'h0,2'd0,4'b0000,4'b0000,0);
    // overflow: five pushes to VC 0, fifth dropped
    add(0,1,32'h40000020,0, 0,32'h0,2'd0,4'b0000,4'b0000,0);
    add(0,1,32'h00000021,0, 1,32'h40000020,2'd0,4'b0000,4'b0000,0);
    add(0,1,32'h00000022,0, 1,32'h40000020,2'd0,4'b0000,4'b0000,0);
    add(0,1,32'h80000023,0, 1,32'h40000020,2'd0,4'b0000,4'b0000,0);
    add(0,1,32'h80000024,0, 1,32'h40000020,2'd0,4'b0000,4'b0000,0);
    add(0,0,32'h0,1,        1,32'h40000020,2'd0,4'b0000,4'b0000,1);
    add(0,0,32'h0,1,        1,32'h00000021,2'd0,4'b0001,4'b0000,1);
    add(0,0,32'h0,1,        1,32'h00000022,2'd0,4'b0001,4'b0000,1);
    add(0,0,32'h0,1,        1,32'h80000023,2'd0,4'b0001,4'b0000,1);
    add(0,0,32'h0,1,        0,32'h0,2'd0,4'b0001,4'b0001,1);
    add(0,0,32'h0,1,        0,32'h0,2'd0,4'b0000,4'b0000,1);
    // backpressure: ready toggles every cycle
    add(0,1,32'h60000001,0, 0,32'h0,2'd0,4'b0000,4'b0000,1);
    add(0,1,32'h20000002,1, 1,32'h60000001,2'd2,4'b0000,4'b0000,1);
    add(0,1,32'hA0000003,0, 1,32'h20000002,2'd2,4'b0100,4'b0000,1);
    add(0,0,32'h0,1,        1,32'h20000002,2'd2,4'b0000,4'b0000,1);
    add(0,0,32'h0,0,        1,32'hA0000003,2'd2,4'b0100,4'b0000,1);
    add(0,0,32'h0,1,        1,32'hA0000003,2'd2,4'b0000,4'b0000,1);
    add(0,0,32'h0,0,        0,32'h0,2'd0,4'b0100,4'b0100,1);
    add(0,0,32'h0,1,        0,32'h0,2'd0,4'b0000,4'b0000,1);
    // mid-packet reset after VC 2 head accepted
    add(0,1,32'h60000001,1, 0,32'h0,2'd0,4'b0000,4'b0000,1);
    add(0,1,32'h20000002,1, 1,32'h60000001,2'd2,4'b0000,4'b0000,1);
    add(1,0,32'h0,1,        0,32'h0,2'd0,4'b0100,4'b0000,1);
    add(0,0,32'h0,1,        0,32'h0,2'd0,4'b0000,4'b0000,0);
    add(0,1,32'hD0000005,1, 0,32'h0,2'd0,4'b0000,4'b0000,0);
    add(0,0,32'h0,1,        1,32'hD0000005,2'd1,4'b0000,4'b0000,0);
    add(0,0,32'h0,1,        0,32'h0,2'd0,4'b0010,4'b0010,0);
    add(0,0,32'h0,1,        0,32'h0,2'd0,4'b0000,4'b0000,0);

    rst            = 1'b1;
    bus.is_valid_i = 1'b0;
    bus.in_link_i  = 32'h0;
    bus.ready_i    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state", 1'b0, 32'h0, 2'd0, 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].vld, vecs[i].flit, vecs[i].rdy);
      check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_flit,
            vecs[i].e_vc, vecs[i].e_cred, vecs[i].e_free, vecs[i].e_ovf);
    end

    // Stalled grant on VC 3 must not be overtaken by a VC 2 arrival (rr_ptr = 2).
    step(0, 1, 32'hF0000030, 0);
    check("hold_empty", 1'b0, 32'h0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    step(0, 1, 32'hE0000031, 0);
    check("hold_offer", 1'b1, 32'hF0000030, 2'd3, 4'b0000, 4'b0000, 1'b0);
    step(0, 0, 32'h0, 0);
    check("hold_stable", 1'b1, 32'hF0000030, 2'd3, 4'b0000, 4'b0000, 1'b0);
    step(0, 0, 32'h0, 1);
    check("hold_accept", 1'b1, 32'hF0000030, 2'd3, 4'b0000, 4'b0000, 1'b0);
    step(0, 0, 32'h0, 1);
    check("hold_next", 1'b1, 32'hE0000031, 2'd2, 4'b1000, 4'b1000, 1'b0);
    step(0, 0, 32'h0, 1);
    check("hold_drain", 1'b0, 32'h0, 2'd0, 4'b0100, 4'b0100, 1'b0);

    // Bounded wait for a VC 0 head-tail to appear.
    step(0, 1, 32'hC0000040, 1);
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      step(0, 0, 32'h0, 1);
      if (bus.out_valid_o === 1'b1) begin
        got = 1'b1;
        check("wait_offer", 1'b1, 32'hC0000040, 2'd0, 4'b0000, 4'b0000, 1'b0);
      end
    end
    if (!got) begin
      total++;
      $display("FAIL wait_offer: got no out_valid within 8 cycles, want a VC 0 offer");
    end
    step(0, 0, 32'h0, 1);
    check("wait_credit", 1'b0, 32'h0, 2'd0, 4'b0001, 4'b0001, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fifo_noc2nic.md
# fifo_noc2nic

Receive-side input buffer of the NIC. It sits directly downstream of the router output link that faces the NIC, the mirror image of `fifo_nic2noc` on the transmit path. It stores incoming flits in one FIFO per virtual channel and returns per-VC credit and free pulses to the router. It presents whole packets, one at a time and without interleaving, to the NoC→WISHBONE master stage.

## Interface
Parameters:
- `FLIT_WIDTH`, default `` `FLIT_WIDTH `` (32): flit width in bits.
- `N_TOT_OF_VC`, default `` `N_OF_VC*`N_OF_VN `` (4): total number of virtual channels.
- `N_BITS_VC`, default `clog2(N_TOT_OF_VC)`: width of a VC id.
- `VC_DEPTH`, default `` `MAX_CREDIT `` (4): flit slots per VC, a power of two.

Ports:
- `clk`  in  1  clock. One clock domain; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `in_link_i`  in  FLIT_WIDTH  flit from the router.
- `is_valid_i`  in  1  `in_link_i` is valid this cycle.
- `credit_signal_o`  out  N_TOT_OF_VC  one-cycle pulse: one slot of VC i has been freed.
- `free_signal_o`  out  N_TOT_OF_VC  one-cycle pulse: VC i has drained a tail flit and is released.
- `out_flit_o`  out  FLIT_WIDTH  flit offered to the consumer.
- `out_vc_id_o`  out  N_BITS_VC  VC of `out_flit_o`.
- `out_valid_o`  out  1  `out_flit_o` is valid.
- `ready_i`  in  1  consumer accepts `out_flit_o`.
- `overflow_o`  out  1  sticky: a flit arrived at a full VC.

## Operation
Flit fields:
- `[FW-1:FW-2]` is the flit type: 00 body, 01 head, 10 tail, 11 head-tail.
- `[FW-3 -: N_BITS_VC]` is the VC id.

Write side:
- When `is_valid_i` is high, the flit is pushed into the FIFO of the VC named by its VC id.
- Fullness is judged on the pre-pop count. If the target VC is full, the flit is dropped and `overflow_o` is set. A pop from the same VC in the same cycle does not allow the push.

Read-side arbiter has two states, IDLE and LOCKED:
- **IDLE.** Round-robin, starting from `rr_ptr`, over the VCs whose FIFO is non-empty and whose front flit is a head or head-tail. The winner drives `out_*` combinationally in the same cycle. Non-empty VCs whose front flit is a body or tail are skipped; this is the protocol-error case and is never selected in IDLE.
- **Accept in IDLE.** When `out_valid_o & ready_i`:
  - Head flit: go to LOCKED on that VC.
  - Head-tail flit: stay IDLE and set `rr_ptr` to winner+1.
- **LOCKED.** Offers only the locked VC. `out_valid_o` is high only while that FIFO is non-empty. On accepting a tail flit, return to IDLE and set `rr_ptr` to locked+1, modulo N_TOT_OF_VC.
- **Pop.** Every accepted flit pops its FIFO. The next cycle, `credit_signal_o[vc]` pulses. If the flit was a tail or head-tail, `free_signal_o[vc]` pulses in that same cycle.
- **Stall.** With `ready_i` low, `out_*` hold stable.

Reset, including reset in the middle of a packet:
- All FIFOs are emptied, state returns to IDLE, `rr_ptr` = 0, `overflow_o` = 0.
- `credit_signal_o`, `free_signal_o` and `out_valid_o` are 0.
- `out_flit_o` and `out_vc_id_o` are 0 while `out_valid_o` is 0.
- No credits are emitted for flits discarded by reset.

## Timing
- **Push to visible:** a flit pushed at edge N is offered on `out_*` from cycle N+1. There is no bypass.
- **Pop to credit:** a flit accepted at edge N produces `credit_signal_o` (and `free_signal_o` if applicable) high during cycle N+1, for exactly one cycle.
- **Throughput:** one push and one pop per cycle, allowed simultaneously, including on the same VC when it is not full.
- **Counters:** per-VC counters are `clog2(VC_DEPTH)+1` bits wide. Read and write pointers wrap modulo VC_DEPTH.
- **Outputs:** all outputs except `out_*` are driven from registers.

## Structure
- The flit-type encodings, the field-offset localparams and `clog2` belong in `NIC-defines.v` / `NIC_utils.vh`.
- One sub-module, `vc_fifo`: a synchronous FIFO with `push`, `pop`, `full`, `empty` and `front`, instantiated N_TOT_OF_VC times in a generate loop.
- The arbiter, the lock FSM and the credit registers live in the top level.

## Test plan
FW = 32, 4 VCs, depth 4.
- **Single packet.** Reset, then push `0x60000001`, `0x20000002`, `0xA0000003` (head/body/tail on VC 2) with `ready_i` = 1. Expect `out_vc_id_o` = 2 and the three flits in order, each one cycle after its push. Expect `credit_signal_o` = 4'b0100 three times, and `free_signal_o` = 4'b0100 only together with the tail's credit.
- **No interleaving.** Push a VC 2 head, then `0xD0000005` (head-tail on VC 1), then the VC 2 body and tail. Expect all of VC 2's packet before the VC 1 flit, then `free_signal_o` = 4'b0010.
- **Round-robin.** Preload head-tail flits on VCs 0, 1 and 3 with `ready_i` = 0, then raise `ready_i`. Expect the grant order 0, 1, 3.
- **Overflow.** With `ready_i` = 0, push five flits to VC 0. Expect `overflow_o` = 1 and only the first four delivered later.
- **Backpressure.** Toggle `ready_i` every cycle. Expect `out_flit_o` stable while stalled, and no credit without an accept.
- **Mid-packet reset.** Assert `rst` after a VC 2 head is accepted. Expect IDLE, all outputs 0, no credit pulse, and correct operation afterwards.
